// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, funct
// codes, ALU function selects, FSM states and instruction classes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLLV = 6'b000100;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_NOR  = 3'd3;
  localparam logic [2:0] ALU_ADD  = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;
  localparam logic [2:0] ALU_SLT  = 3'd6;
  localparam logic [2:0] ALU_SLLV = 3'd7;

  // BOOT must stay the all-zero encoding so the reset value lands there.
  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IDLE = 3'd1,
    ST_DEC  = 3'd2,
    ST_EXE  = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_RTYPE = 2'd0,
    CLS_LW    = 2'd1,
    CLS_SW    = 2'd2,
    CLS_BAD   = 2'd3
  } iclass_e;

endpackage

// File: rtl/mc_instr_decode.sv
// Purely combinational decode of one instruction word into its class and
// the datapath control fields the sequencer latches at accept.
module mc_instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_e     cls,
  output logic [2:0]  alu_op,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [4:0]  w_addr,
  output logic        legal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    cls        = CLS_BAD;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    w_addr     = 5'd0;
    legal      = 1'b0;
    case (opcode)
      OP_LW, OP_SW: begin
        cls        = (opcode == OP_LW) ? CLS_LW : CLS_SW;
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        w_addr     = instr[20:16];
        legal      = 1'b1;
      end
      OP_RTYPE: begin
        cls    = CLS_RTYPE;
        w_addr = instr[15:11];
        legal  = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLLV: alu_op = ALU_SLLV;
          default: begin
            cls   = CLS_BAD;
            legal = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencer: accepts one instruction over valid/ready and walks
// the datapath through DEC/EXE/MEM/WB with fully registered control outputs.
module mc_seq_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int OFF_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              OF,
  input  logic              ZF,
  output logic              Write_Reg,
  output logic              Mem_Write,
  output logic [OFF_W-1:0]  offset,
  output logic [2:0]        ALU_OP,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [ADDR_W-1:0] RS,
  output logic [ADDR_W-1:0] RT,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              ovf_trap,
  output logic [CNT_W-1:0]  retired_cnt
);

  state_e            state_q, state_d;
  iclass_e           cls_q, cls_d, dec_cls;
  logic [2:0]        alu_op_q, alu_op_d, dec_alu_op;
  logic              alu_src_q, alu_src_d, dec_alu_src;
  logic              m2r_q, m2r_d, dec_m2r;
  logic [4:0]        dec_w_addr;
  logic              dec_legal;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d, rs_q, rs_d, rt_q, rt_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              ready_q, ready_d, busy_q, busy_d;
  logic              wr_q, wr_d, mw_q, mw_d;
  logic              done_q, done_d, ill_q, ill_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_addsub;
  logic              unused_zf;

  assign unused_zf = ZF;
  assign is_addsub = (alu_op_q == ALU_ADD) || (alu_op_q == ALU_SUB);

  mc_instr_decode u_dec (
    .instr      (instr),
    .cls        (dec_cls),
    .alu_op     (dec_alu_op),
    .alu_src    (dec_alu_src),
    .mem_to_reg (dec_m2r),
    .w_addr     (dec_w_addr),
    .legal      (dec_legal)
  );

  // Datapath fields only change at accept, so they hold through IDLE.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    alu_op_d  = alu_op_q;
    alu_src_d = alu_src_q;
    m2r_d     = m2r_q;
    w_addr_d  = w_addr_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    off_d     = off_q;
    done_d    = 1'b0;
    ill_d     = 1'b0;
    ovf_d     = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      ST_BOOT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (instr_valid) begin
          state_d = ST_DEC;
          cls_d   = dec_cls;
          rs_d    = ADDR_W'(instr[25:21]);
          rt_d    = ADDR_W'(instr[20:16]);
          if (dec_legal) begin
            alu_op_d  = dec_alu_op;
            alu_src_d = dec_alu_src;
            m2r_d     = dec_m2r;
            w_addr_d  = ADDR_W'(dec_w_addr);
            off_d     = OFF_W'(instr[15:0]);
          end
        end
      end
      ST_DEC: begin
        if (cls_q == CLS_BAD) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ill_d   = 1'b1;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        if (cls_q == CLS_RTYPE && is_addsub && OF) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          ovf_d   = 1'b1;
        end else if (cls_q == CLS_RTYPE) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        if (cls_q == CLS_SW) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_BOOT;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_DEC) || (state_d == ST_EXE) ||
              (state_d == ST_MEM) || (state_d == ST_WB);
    wr_d    = (state_d == ST_WB) && (w_addr_d != '0);
    mw_d    = (state_d == ST_MEM) && (cls_q == CLS_SW);
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_BOOT;
      cls_q     <= CLS_RTYPE;
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      m2r_q     <= 1'b0;
      w_addr_q  <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      off_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      mw_q      <= 1'b0;
      done_q    <= 1'b0;
      ill_q     <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      m2r_q     <= m2r_d;
      w_addr_q  <= w_addr_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      off_q     <= off_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      mw_q      <= mw_d;
      done_q    <= done_d;
      ill_q     <= ill_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign Write_Reg   = wr_q;
  assign Mem_Write   = mw_q;
  assign done        = done_q;
  assign illegal     = ill_q;
  assign ovf_trap    = ovf_q;
  assign retired_cnt = cnt_q;
  assign offset      = off_q;
  assign ALU_OP      = alu_op_q;
  assign alu_src     = alu_src_q;
  assign mem_to_reg  = m2r_q;
  assign W_Addr      = w_addr_q;
  assign RS          = rs_q;
  assign RT          = rt_q;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Self-checking bench for mc_seq_ctrl: directed scenarios plus randomized
// instructions compared against a per-instruction timing/field model.
module tb_mc_seq_ctrl;

  localparam int CW = 2;

  logic          clk;
  logic          Reset;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          OF;
  logic          ZF;
  logic          Write_Reg;
  logic          Mem_Write;
  logic [15:0]   offset;
  logic [2:0]    ALU_OP;
  logic          alu_src;
  logic          mem_to_reg;
  logic [4:0]    W_Addr;
  logic [4:0]    RS;
  logic [4:0]    RT;
  logic          busy;
  logic          done;
  logic          illegal;
  logic          ovf_trap;
  logic [CW-1:0] retired_cnt;

  int checks;
  int failures;
  int exp_cnt;

  // Observation window after accept: index k is sampled just after the k-th
  // clock edge following the accepting edge (k = 0 is the DEC cycle).
  logic [6:0] o_wr, o_mw, o_done, o_ill, o_ovf, o_busy;
  logic [4:0] o_wa [7];
  logic [4:0] d_rs, d_rt;
  logic [15:0] d_off;
  logic [2:0] d_aop;
  logic d_src, d_m2r;
  int extra_acc;

  // ALU code of each funct is its position in this table.
  logic [5:0] fn_tab [8] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2A, 6'h04};

  typedef struct {
    int         lat;
    bit         ill;
    bit         ovf;
    int         wr_at;
    int         mw_at;
    logic [2:0] aop;
    bit         src;
    bit         m2r;
    logic [4:0] wa;
  } exp_t;

  mc_seq_ctrl #(.ADDR_W(5), .OFF_W(16), .CNT_W(CW)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .OF          (OF),
    .ZF          (ZF),
    .Write_Reg   (Write_Reg),
    .Mem_Write   (Mem_Write),
    .offset      (offset),
    .ALU_OP      (ALU_OP),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .W_Addr      (W_Addr),
    .RS          (RS),
    .RT          (RT),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .ovf_trap    (ovf_trap),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] at(input int k);
    logic [6:0] v;
    v = '0;
    if (k >= 0 && k <= 6) v[k] = 1'b1;
    return v;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic ofv);
    exp_t e;
    e = '{lat: 1, ill: 1'b1, ovf: 1'b0, wr_at: -1, mw_at: -1,
          aop: 3'd4, src: 1'b1, m2r: 1'b1, wa: ins[20:16]};
    if (ins[31:26] == 6'h23) begin
      e.ill = 1'b0; e.lat = 4;
      e.wr_at = (ins[20:16] != 0) ? 3 : -1;
    end else if (ins[31:26] == 6'h2B) begin
      e.ill = 1'b0; e.lat = 3; e.mw_at = 2;
    end else if (ins[31:26] == 6'h00) begin
      for (int i = 0; i < 8; i++) begin
        if (fn_tab[i] == ins[5:0]) begin
          e.ill = 1'b0; e.aop = 3'(i); e.src = 1'b0; e.m2r = 1'b0; e.wa = ins[15:11];
          if ((i == 4 || i == 5) && ofv) begin
            e.ovf = 1'b1; e.lat = 2;
          end else begin
            e.lat = 3;
            e.wr_at = (ins[15:11] != 0) ? 2 : -1;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] ins, input logic ofv, input bit hold);
    int w;
    w = 0;
    @(negedge clk);
    instr = ins; OF = ofv; instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 20) begin
      failures++;
      $display("[TB] FAIL accept_timeout: instr_ready=%b after %0d cycles, required 1", instr_ready, w);
    end
    extra_acc = 0;
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
    instr = $urandom;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        if (instr_valid && instr_ready) extra_acc++;
        @(posedge clk); #1;
      end
      o_wr[k] = Write_Reg; o_mw[k] = Mem_Write; o_done[k] = done;
      o_ill[k] = illegal; o_ovf[k] = ovf_trap; o_busy[k] = busy; o_wa[k] = W_Addr;
      if (k == 0) begin
        d_rs = RS; d_rt = RT; d_off = offset; d_aop = ALU_OP; d_src = alu_src; d_m2r = mem_to_reg;
      end
      if (done === 1'b1) instr_valid = 1'b0;
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; instr = '0; instr_valid = 1'b0; OF = 1'b0; ZF = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({instr_ready, Write_Reg, Mem_Write, offset, ALU_OP, alu_src, mem_to_reg, W_Addr,
         RS, RT, busy, done, illegal, ovf_trap, retired_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: ready=%b wr=%b mw=%b busy=%b done=%b cnt=%0d, required all 0",
               instr_ready, Write_Reg, Mem_Write, busy, done, retired_cnt);
    end
    Reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL boot_to_idle: ready=%b busy=%b, required ready=1 busy=0", instr_ready, busy);
    end
    exp_cnt = 0;
  endtask

  task automatic test_lw();
    issue(32'h8C010004, 1'b0, 1'b0);
    exp_cnt++;
    checks++;
    if (d_rs !== 5'd0 || d_off !== 16'd4 || d_aop !== 3'd4 || d_src !== 1'b1 || d_m2r !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lw_fields: rs=%0d off=%0d aop=%0d src=%b m2r=%b, required 0 4 4 1 1",
               d_rs, d_off, d_aop, d_src, d_m2r);
    end
    checks++;
    if (o_wr !== at(3) || o_wa[3] !== 5'd1 || o_mw !== '0) begin
      failures++;
      $display("[TB] FAIL lw_write: wr=%b wa=%0d mw=%b, required wr=%b wa=1 mw=0", o_wr, o_wa[3], o_mw, at(3));
    end
    checks++;
    if (o_done !== at(4) || retired_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL lw_done: done=%b cnt=%0d, required done=%b cnt=%0d", o_done, retired_cnt, at(4), CW'(exp_cnt));
    end
  endtask

  task automatic test_sw();
    issue(32'hAC210004, 1'b0, 1'b0);
    exp_cnt++;
    checks++;
    if (o_mw !== at(2) || o_wr !== '0) begin
      failures++;
      $display("[TB] FAIL sw_enables: mw=%b wr=%b, required mw=%b wr=0", o_mw, o_wr, at(2));
    end
    checks++;
    if (o_done !== at(3) || d_rs !== 5'd1 || d_rt !== 5'd1 || d_off !== 16'd4) begin
      failures++;
      $display("[TB] FAIL sw_done: done=%b rs=%0d rt=%0d off=%0d, required done=%b 1 1 4", o_done, d_rs, d_rt, d_off, at(3));
    end
  endtask

  task automatic test_add();
    issue(32'h00221820, 1'b0, 1'b0);
    exp_cnt++;
    checks++;
    if (d_aop !== 3'd4 || d_src !== 1'b0 || d_m2r !== 1'b0 || o_wr !== at(2) || o_wa[2] !== 5'd3) begin
      failures++;
      $display("[TB] FAIL add_exec: aop=%0d src=%b wr=%b wa=%0d, required 4 0 %b 3", d_aop, d_src, o_wr, o_wa[2], at(2));
    end
    checks++;
    if (o_done !== at(3) || retired_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL add_done: done=%b cnt=%0d, required %b %0d", o_done, retired_cnt, at(3), CW'(exp_cnt));
    end
  endtask

  task automatic test_add_ovf();
    issue(32'h00221820, 1'b1, 1'b0);
    checks++;
    if (o_ovf !== at(2) || o_done !== at(2) || o_wr !== '0 || o_ill !== '0) begin
      failures++;
      $display("[TB] FAIL add_ovf: ovf=%b done=%b wr=%b ill=%b, required ovf=done=%b wr=ill=0", o_ovf, o_done, o_wr, o_ill, at(2));
    end
    checks++;
    if (retired_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL ovf_count: cnt=%0d, required %0d", retired_cnt, CW'(exp_cnt));
    end
  endtask

  task automatic test_illegal_hold();
    issue(32'hFC000000, 1'b0, 1'b1);
    checks++;
    if (o_done !== at(1) || o_ill !== at(1) || o_wr !== '0 || o_mw !== '0 || extra_acc !== 0) begin
      failures++;
      $display("[TB] FAIL illegal: done=%b ill=%b wr=%b mw=%b extra=%0d, required done=ill=%b rest 0",
               o_done, o_ill, o_wr, o_mw, extra_acc, at(1));
    end
    issue(32'h8C420010, 1'b0, 1'b1);
    exp_cnt++;
    checks++;
    if (extra_acc !== 0 || o_done !== at(4) || o_busy !== 7'b0001111) begin
      failures++;
      $display("[TB] FAIL busy_hold: extra=%0d done=%b busy=%b, required 0 %b 0001111", extra_acc, o_done, o_busy, at(4));
    end
  endtask

  task automatic test_r0_suppress();
    issue(32'h00220020, 1'b0, 1'b0);
    exp_cnt++;
    checks++;
    if (o_wr !== '0 || o_done !== at(3) || retired_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL r0_suppress: wr=%b done=%b cnt=%0d, required wr=0 done=%b cnt=%0d",
               o_wr, o_done, retired_cnt, at(3), CW'(exp_cnt));
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] ins;
    logic ofv;
    exp_t e;
    logic [6:0] eb;
    for (int t = 0; t < n; t++) begin
      case ($urandom_range(0, 3))
        0: ins = {6'h23, 26'($urandom)};
        1: ins = {6'h2B, 26'($urandom)};
        2: begin
          ins = {6'h00, 26'($urandom)};
          if ($urandom_range(0, 3) != 0) ins[5:0] = fn_tab[$urandom_range(0, 7)];
        end
        default: ins = $urandom;
      endcase
      ofv = 1'($urandom_range(0, 1));
      issue(ins, ofv, 1'($urandom_range(0, 1)));
      e = model(ins, ofv);
      eb = '0;
      for (int k = 0; k < e.lat; k++) eb[k] = 1'b1;
      if (!e.ill && !e.ovf) exp_cnt++;
      checks++;
      if (o_done !== at(e.lat) || o_ill !== (e.ill ? at(e.lat) : 7'b0) ||
          o_ovf !== (e.ovf ? at(e.lat) : 7'b0) || o_busy !== eb) begin
        failures++;
        $display("[TB] FAIL rnd_timing %08h of=%b: done=%b ill=%b ovf=%b busy=%b, required lat=%0d ill=%b ovf=%b busy=%b",
                 ins, ofv, o_done, o_ill, o_ovf, o_busy, e.lat, e.ill, e.ovf, eb);
      end
      checks++;
      if (o_wr !== at(e.wr_at) || o_mw !== at(e.mw_at) || extra_acc !== 0) begin
        failures++;
        $display("[TB] FAIL rnd_enables %08h: wr=%b mw=%b extra=%0d, required wr=%b mw=%b extra=0",
                 ins, o_wr, o_mw, extra_acc, at(e.wr_at), at(e.mw_at));
      end
      if (!e.ill) begin
        checks++;
        if (d_rs !== ins[25:21] || d_rt !== ins[20:16] || d_aop !== e.aop ||
            d_src !== e.src || d_m2r !== e.m2r || o_wa[0] !== e.wa) begin
          failures++;
          $display("[TB] FAIL rnd_fields %08h: rs=%0d rt=%0d aop=%0d src=%b m2r=%b wa=%0d, required %0d %0d %0d %b %b %0d",
                   ins, d_rs, d_rt, d_aop, d_src, d_m2r, o_wa[0], ins[25:21], ins[20:16], e.aop, e.src, e.m2r, e.wa);
        end
      end
      checks++;
      if (retired_cnt !== CW'(exp_cnt)) begin
        failures++;
        $display("[TB] FAIL rnd_count %08h: cnt=%0d, required %0d", ins, retired_cnt, CW'(exp_cnt));
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    bit wr_seen;
    w = 0;
    wr_seen = 1'b0;
    @(negedge clk);
    instr = 32'h8C220008; OF = 1'b0; instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || Write_Reg !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_in_mem: busy=%b wr=%b, required busy=1 wr=0", busy, Write_Reg);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({instr_ready, Write_Reg, Mem_Write, offset, ALU_OP, alu_src, mem_to_reg, W_Addr,
         RS, RT, busy, done, illegal, ovf_trap, retired_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: busy=%b wr=%b cnt=%0d off=%0d, required all 0", busy, Write_Reg, retired_cnt, offset);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (Write_Reg !== 1'b0) wr_seen = 1'b1;
    end
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk); #1;
    if (Write_Reg !== 1'b0) wr_seen = 1'b1;
    exp_cnt = 0;
    checks++;
    if (wr_seen !== 1'b0 || instr_ready !== 1'b1 || retired_cnt !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_recover: wr_seen=%b ready=%b cnt=%0d, required 0 1 0", wr_seen, instr_ready, retired_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 5; i++) begin
      issue(32'h8C020000, 1'b0, 1'b0);
      exp_cnt++;
    end
    checks++;
    if (retired_cnt !== 2'd1) begin
      failures++;
      $display("[TB] FAIL cnt_wrap: cnt=%0d, required 1", retired_cnt);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_cnt = 0;
    test_reset();
    test_lw();
    test_sw();
    test_add();
    test_add_ovf();
    test_illegal_hold();
    test_r0_suppress();
    test_random(40);
    test_reset_mid();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
